// File: rtl/xevious_pkg.sv
// Shared constants and types for the ROM download path: region map,
// download timing constants and the loader state encoding.
package xevious_pkg;

  localparam int unsigned HOLD_CYCLES = 1024;
  localparam int unsigned ACK_TIMEOUT = 255;
  localparam int unsigned TOTAL_BYTES = 32'h20000;

  localparam int NUM_REGIONS = 4;

  // Entry [i] describes region Ri; limits are inclusive.
  localparam logic [NUM_REGIONS-1:0][24:0] REGION_BASE =
    {25'h18000, 25'h14000, 25'h10000, 25'h00000};
  localparam logic [NUM_REGIONS-1:0][24:0] REGION_LIMIT =
    {25'h1FFFF, 25'h17FFF, 25'h13FFF, 25'h0FFFF};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational region decoder: maps a download byte address onto a
// one-hot region hit and the byte offset inside that region.
module rom_region_dec
  import xevious_pkg::*;
(
  input  logic [24:0]            addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [16:0]            rel_addr
);

  // Compare against every region window; addresses past the image hit nothing.
  always_comb begin
    hit      = '0;
    rel_addr = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (addr >= REGION_BASE[i] && addr <= REGION_LIMIT[i]) begin
        hit[i]   = 1'b1;
        rel_addr = 17'(addr - REGION_BASE[i]);
      end
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: steers HPS download bytes into four ROM regions,
// applies backpressure while a region write is outstanding, and keeps the
// game core in reset until a complete, error-free image has been loaded.
module rom_load_ctrl
  import xevious_pkg::*;
#(
  parameter int unsigned P_HOLD_CYCLES = HOLD_CYCLES,
  parameter int unsigned P_ACK_TIMEOUT = ACK_TIMEOUT,
  parameter int unsigned P_TOTAL_BYTES = TOTAL_BYTES
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [3:0]  rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic [3:0]  rom_ack,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int HOLD_W = $clog2(P_HOLD_CYCLES + 1);
  localparam int ACK_W  = $clog2(P_ACK_TIMEOUT + 1);

  load_state_e       state_q, state_d;
  logic [17:0]       cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic [3:0]        we_q, we_d;
  logic [16:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              core_rst_q, core_rst_d;
  logic              dl_q;

  logic [3:0]        dec_hit;
  logic [16:0]       dec_rel;
  logic              dl_rise;
  logic              acked;
  logic              write_end;

  rom_region_dec u_dec (
    .addr     (ioctl_addr),
    .hit      (dec_hit),
    .rel_addr (dec_rel)
  );

  assign dl_rise = ioctl_download & ~dl_q;
  assign acked   = |(rom_ack & we_q);

  // Next-state and output decisions for the download sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    ack_d      = ack_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    done_d     = done_q;
    core_rst_d = core_rst_q;
    write_end  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          core_rst_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (ioctl_wr) begin
          if (|dec_hit) begin
            we_d    = dec_hit;
            addr_d  = dec_rel;
            data_d  = ioctl_dout;
            ack_d   = '0;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else if (!ioctl_download) begin
          hold_d  = '0;
          state_d = ST_HOLD;
        end
      end

      ST_WRITE: begin
        // A strobe while backpressure is up is an overrun; the byte is lost.
        if (ioctl_wr) begin
          err_d = 1'b1;
        end
        if (acked) begin
          we_d      = '0;
          cnt_d     = (cnt_q == 18'h3FFFF) ? cnt_q : cnt_q + 18'd1;
          write_end = 1'b1;
        end else if (ack_q == ACK_W'(P_ACK_TIMEOUT - 1)) begin
          we_d      = '0;
          err_d     = 1'b1;
          write_end = 1'b1;
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
        // If the download ended while this byte was in flight, go straight to HOLD.
        if (write_end) begin
          hold_d  = '0;
          state_d = ioctl_download ? ST_LOAD : ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          core_rst_d = 1'b1;
        end else if (hold_q == HOLD_W'(P_HOLD_CYCLES - 1)) begin
          state_d = ST_DONE;
          if (cnt_q == 18'(P_TOTAL_BYTES) && !err_q) begin
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset parks the core in reset with no write pending.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      ack_q      <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      dl_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      dl_q       <= ioctl_download;
    end
  end

  assign ioctl_wait = |we_q;
  assign rom_we     = we_q;
  assign rom_addr   = addr_q;
  assign rom_data   = data_q;
  assign core_reset = core_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl with a shortened image size so full
// downloads stay short; region map, hold and ack timeout use real values.
module tb_rom_load_ctrl;

  localparam int IMG = 32;

  typedef struct packed {
    logic [3:0]  we;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [3:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_ack = '0;
  logic        core_reset;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  exp_t obs_q[$];

  int   ack_delay  = 1;
  bit   ack_enable = 1'b1;
  bit   ack_noise  = 1'b0;
  int   ack_age    = 0;

  logic [3:0]  prev_we = '0;
  exp_t        cap;
  bit          wr_stable = 1'b1;
  int          wait_cnt  = 0;

  rom_load_ctrl #(
    .P_TOTAL_BYTES (IMG)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_ack        (rom_ack),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  always #5 clk_sys = ~clk_sys;

  // ROM side model: acknowledge ack_delay cycles after a write appears,
  // optionally spraying acks on the other region bits meanwhile.
  always @(negedge clk_sys) begin
    rom_ack = '0;
    if (rom_we != 4'b0000) begin
      if (ack_enable && ack_age == ack_delay) rom_ack = rom_we;
      else if (ack_noise) rom_ack = ~rom_we;
      ack_age++;
    end else begin
      ack_age = 0;
    end
  end

  // Capture each write as it starts; track stability and backpressure length.
  always @(negedge clk_sys) begin
    if (rom_we != 4'b0000 && prev_we == 4'b0000) begin
      cap       = '{we: rom_we, addr: rom_addr, data: rom_data};
      obs_q.push_back(cap);
      wr_stable = 1'b1;
      wait_cnt  = 0;
    end
    if (rom_we != 4'b0000 && {rom_we, rom_addr, rom_data} !== cap) wr_stable = 1'b0;
    if (ioctl_wait === 1'b1) wait_cnt++;
    prev_we = rom_we;
  end

  function automatic exp_t tb_expect(input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.we   = 4'b0000;
    e.addr = '0;
    if (a < 25'h10000) begin
      e.we = 4'b0001; e.addr = a[16:0];
    end else if (a < 25'h14000) begin
      e.we = 4'b0010; e.addr = 17'(a - 25'h10000);
    end else if (a < 25'h18000) begin
      e.we = 4'b0100; e.addr = 17'(a - 25'h14000);
    end else if (a < 25'h20000) begin
      e.we = 4'b1000; e.addr = 17'(a - 25'h18000);
    end
    return e;
  endfunction

  function automatic logic [24:0] img_addr(input int i);
    case (i)
      0: return 25'h00000;
      1: return 25'h0FFFF;
      2: return 25'h10000;
      3: return 25'h13FFF;
      4: return 25'h14000;
      5: return 25'h14005;
      6: return 25'h17FFF;
      7: return 25'h18000;
      8: return 25'h1FFFF;
      default: return 25'(i * 4099);
    endcase
  endfunction

  // Compare the oldest observed write against the oldest expected one.
  task automatic sb_compare(input string name);
    exp_t e;
    exp_t o;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: write missing (observed=%0d expected=%0d queued)",
               name, obs_q.size(), exp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                 name, o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
  endtask

  // Drive one byte at a negedge and wait for any backpressure to clear.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output int wlen);
    exp_t e;
    e = tb_expect(a, d);
    if (e.we != 4'b0000) exp_q.push_back(e);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    for (int i = 0; i < 400 && ioctl_wait; i++) @(negedge clk_sys);
    if (ioctl_wait) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_bound: ioctl_wait=%b, want 0 within 400 cycles", ioctl_wait);
    end
    wlen = (e.we != 4'b0000) ? wait_cnt : 0;
    if (e.we != 4'b0000) sb_compare("sb_write");
  endtask

  task automatic load_image(input int n, input int seed, input bit chk_wait, input int exp_wait);
    int wlen;
    for (int i = 0; i < n; i++) begin
      send_byte(img_addr(i), 8'(i * 7 + seed), wlen);
      if (chk_wait) begin
        checks++;
        if (wlen != exp_wait) begin
          errors++;
          $display("[TB] FAIL wait_len byte %0d: got %0d, want %0d", i, wlen, exp_wait);
        end
      end
    end
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  // End the download and measure core_reset release, counted from the edge
  // that registers the end of the download.
  task automatic end_download_clean();
    int n;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    n = 0;
    while (n < 2000) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (core_reset === 1'b0) break;
    end
    checks++;
    if (n != 1024) begin
      errors++;
      $display("[TB] FAIL hold_len: core_reset fell after %0d cycles, want 1024", n);
    end
    @(negedge clk_sys);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_done: load_done=%b load_err=%b, want 1 0", load_done, load_err);
    end
  endtask

  task automatic end_download_fail(input string name);
    ioctl_download = 1'b0;
    repeat (1100) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: core_reset=%b load_done=%b load_err=%b, want 1 0 1",
               name, core_reset, load_done, load_err);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ioctl_wait, rom_we, rom_addr, rom_data, load_done, load_err} !== '0 || core_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_vals: wait=%b we=%b addr=%h data=%h done=%b err=%b core_reset=%b",
               ioctl_wait, rom_we, rom_addr, rom_data, load_done, load_err, core_reset);
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (50) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_download: core_reset=%b load_done=%b, want 1 0", core_reset, load_done);
    end
  endtask

  task automatic test_full_load();
    ack_noise = 1'b1;
    ack_delay = 1;
    start_download();
    load_image(IMG, 3, 1'b1, 2);
    ack_noise = 1'b0;
    end_download_clean();
  endtask

  task automatic test_ack_delay();
    int wlen;
    start_download();
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_from_done: core_reset=%b load_done=%b, want 1 0", core_reset, load_done);
    end
    ack_delay = 10;
    send_byte(25'h14005, 8'hA5, wlen);
    checks++;
    if (wlen != 11 || !wr_stable) begin
      errors++;
      $display("[TB] FAIL ack_delay10: wait_len=%0d stable=%0d, want 11 1", wlen, wr_stable);
    end
    ack_enable = 1'b0;
    send_byte(25'h1C000, 8'h3C, wlen);
    checks++;
    if (wlen != 255 || load_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_timeout: wait_len=%0d load_err=%b, want 255 1", wlen, load_err);
    end
    ack_enable = 1'b1;
    ack_delay  = 1;
    send_byte(25'h00010, 8'h77, wlen);
    checks++;
    if (wlen != 2) begin
      errors++;
      $display("[TB] FAIL after_timeout: wait_len=%0d, want 2", wlen);
    end
    end_download_fail("timeout_done");
  endtask

  task automatic test_bad_writes();
    int wlen;
    start_download();
    load_image(IMG, 9, 1'b0, 0);
    send_byte(25'h20010, 8'hEE, wlen);
    checks++;
    if (load_err !== 1'b1 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_of_range: load_err=%b wait=%b, want 1 0", load_err, ioctl_wait);
    end
    end_download_fail("range_done");

    start_download();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: load_err=%b, want 0", load_err);
    end
    ack_delay = 5;
    exp_q.push_back(tb_expect(25'h12345, 8'h5C));
    ioctl_addr = 25'h12345; ioctl_dout = 8'h5C; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 25'h00020; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    for (int i = 0; i < 400 && ioctl_wait; i++) @(negedge clk_sys);
    sb_compare("overrun_first");
    checks++;
    if (load_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun: load_err=%b, want 1", load_err);
    end
    ack_delay = 1;
    load_image(IMG - 1, 21, 1'b0, 0);
    end_download_fail("overrun_done");
  endtask

  task automatic test_short_then_clean();
    start_download();
    load_image(IMG - 1, 40, 1'b0, 0);
    end_download_fail("short_done");
    start_download();
    checks++;
    if (load_err !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL second_start: load_err=%b core_reset=%b, want 0 1", load_err, core_reset);
    end
    load_image(IMG, 55, 1'b0, 0);
    end_download_clean();
  endtask

  task automatic test_reset_mid_write();
    int wlen;
    start_download();
    send_byte(25'h20000, 8'h01, wlen);
    ack_enable = 1'b0;
    exp_q.push_back(tb_expect(25'h10020, 8'hC3));
    ioctl_addr = 25'h10020; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b1 || load_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: wait=%b load_err=%b, want 1 1", ioctl_wait, load_err);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ioctl_wait, rom_we, rom_addr, rom_data, load_done, load_err} !== '0 || core_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: wait=%b we=%b addr=%h data=%h done=%b err=%b core_reset=%b",
               ioctl_wait, rom_we, rom_addr, rom_data, load_done, load_err, core_reset);
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n    = 1'b1;
    ack_enable = 1'b1;
    repeat (20) @(negedge clk_sys);
    sb_compare("mid_write_seen");
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0 || rom_we !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL post_reset: core_reset=%b load_done=%b we=%b, want 1 0 0000",
               core_reset, load_done, rom_we);
    end
  endtask

  task automatic test_hold_restart();
    start_download();
    load_image(IMG, 70, 1'b0, 0);
    ioctl_download = 1'b0;
    repeat (100) @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_reassert: core_reset=%b done=%b err=%b, want 1 0 0",
               core_reset, load_done, load_err);
    end
    repeat (1100) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_abandoned: core_reset=%b done=%b, want 1 0", core_reset, load_done);
    end
    load_image(IMG, 90, 1'b0, 0);
    end_download_clean();
  endtask

  task automatic test_drained();
    repeat (5) @(negedge clk_sys);
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drained: expected left=%0d observed left=%0d, want 0 0",
               exp_q.size(), obs_q.size());
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_full_load();
    test_ack_delay();
    test_bad_writes();
    test_short_then_clean();
    test_reset_mid_write();
    test_hold_restart();
    test_drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first (name  direction  width  meaning):
 clk_sys  in  1  system clock, shared with hps_io and core;
 reset_n  in  1  asynchronous, active-low reset;
 ioctl_download  in  1  HPS download-active level;
 ioctl_wr  in  1  single-cycle byte-write strobe;
 ioctl_addr  in  25  download byte address;
 ioctl_dout  in  8  download byte;
 ioctl_wait  out  1  backpressure to HPS;
 rom_we  out  4  one-hot region write request;
 rom_addr  out  17  region-relative byte address;
 rom_data  out  8  byte to write;
 rom_ack  in  4  per-region write acknowledge;
 core_reset  out  1  active-high reset to game core;
 load_done  out  1  image loaded cleanly;
 load_err  out  1  sticky load error.
REQ-002 SHALL take these constants (name, default, meaning): HOLD_CYCLES, 1024, core-reset stretch after download; ACK_TIMEOUT, 255, max cycles waiting for rom_ack; TOTAL_BYTES, 0x20000, expected image size.

Function
REQ-003 SHALL decode ioctl_addr against four regions: R0 0x00000-0x0FFFF, R1 0x10000-0x13FFF, R2 0x14000-0x17FFF, R3 0x18000-0x1FFFF; addresses >= 0x20000 match no region.
REQ-004 SHALL set rom_addr = ioctl_addr - region base (17 bits, upper bits zero for smaller regions).
REQ-005 SHALL implement FSM states IDLE, LOAD, WRITE, HOLD, DONE.
REQ-006 IDLE/DONE: on ioctl_download 0->1 SHALL enter LOAD, clear byte counter, load_done, load_err; core_reset asserted in the same cycle as the transition.
REQ-007 LOAD: ioctl_wr with matching region SHALL register address/data, enter WRITE; rom_we one-hot and ioctl_wait high from the next cycle (latency 1).
REQ-008 LOAD: ioctl_wr with no matching region SHALL drop the byte, set load_err, stay in LOAD, not increment counter.
REQ-009 WRITE: rom_we, rom_addr, rom_data SHALL stay stable until the matching rom_ack bit is seen; cycle after ack: rom_we=0, ioctl_wait=0, counter+1, return to LOAD.
REQ-010 WRITE: if ACK_TIMEOUT cycles elapse without ack, SHALL abandon the byte, set load_err, deassert rom_we/ioctl_wait, return to LOAD.
REQ-011 ioctl_wr while ioctl_wait=1 SHALL be ignored and set load_err (overrun).
REQ-012 rom_ack bits other than the active region SHALL be ignored.
REQ-013 ioctl_download 1->0 in LOAD SHALL enter HOLD; in WRITE SHALL complete (or time out) the pending write first, then enter HOLD.
REQ-014 HOLD: core_reset SHALL remain 1 for exactly HOLD_CYCLES cycles, then enter DONE.
REQ-015 DONE: if counter == TOTAL_BYTES and load_err=0: load_done=1, core_reset=0; otherwise load_err=1, core_reset stays 1.
REQ-016 Byte counter SHALL be 18 bits, saturating at 0x3FFFF.
REQ-017 ioctl_download re-asserting during HOLD SHALL return to LOAD with counter/flags cleared.

Reset
REQ-018 reset_n low SHALL asynchronously force IDLE, core_reset=1, ioctl_wait=0, rom_we=0, rom_addr=0, rom_data=0, load_done=0, load_err=0, counters=0.
REQ-019 reset mid-WRITE SHALL drop the pending byte without completing; core stays in reset until a full clean load.

Structure
REQ-020 Region base/limit table, TOTAL_BYTES, HOLD_CYCLES, ACK_TIMEOUT and the FSM state enum SHALL live in shared package xevious_pkg.
REQ-021 Region decode SHALL be a sub-module rom_region_dec (combinational: addr -> one-hot hit, relative address).

Verification
REQ-022 Power-up, reset_n released, no download -> core_reset=1, load_done=0 indefinitely.
REQ-023 Full 0x20000-byte download, rom_ack one cycle after rom_we -> every byte lands in correct region with correct relative address (e.g. 0x14005 -> rom_we=4'b0100, rom_addr=0x00005); core_reset falls exactly 1024 cycles after download end; load_done=1.
REQ-024 rom_ack delayed 10 cycles -> ioctl_wait high 11 cycles, data/address stable throughout; no ack for 255 cycles -> load_err=1, FSM back in LOAD.
REQ-025 Write to 0x20010 and a second ioctl_wr during ioctl_wait -> both dropped, load_err=1, at DONE core_reset stays 1.
REQ-026 Download ends with 0x1FFFF bytes -> load_err=1, load_done=0; second clean download -> load_err cleared, load_done=1.
REQ-027 reset_n pulsed mid-WRITE and ioctl_download re-asserted during HOLD -> outputs at reset values immediately; HOLD restarts as LOAD with counter 0.
